// File: rtl/dense_act_stage_if.sv
// Result stream from dense_act_stage to the next layer's input FIFO.
// A beat transfers on any rising edge where out_valid and out_ready are both high.
interface dense_act_stage_if #(
    parameter int OUT_WIDTH = 8
);
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/dense_act_stage.sv
// Post-MAC output stage of a dense layer.
// Captures NO_NPL accumulators and biases on a start pulse, then adds the bias
// to each neuron, applies ReLU or linear pass-through, rescales and saturates
// the result to OUT_WIDTH, and buffers it (one neuron per cycle). The buffered
// results are then streamed out over a valid/ready handshake.
// OUT_WIDTH must not exceed ACC_WIDTH+1, and BIAS_WIDTH+SHIFT must not exceed ACC_WIDTH.
module dense_act_stage #(
    parameter int NO_NPL     = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int BIAS_WIDTH = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         act_fn_en,
    input  logic                         feed_through,
    input  logic [NO_NPL*ACC_WIDTH-1:0]  acc_in,
    input  logic [NO_NPL*BIAS_WIDTH-1:0] bias_in,
    dense_act_stage_if.master            stream,
    output logic                         busy,
    output logic                         done
);

    // One extra bit over the accumulator absorbs the shifted bias without overflow.
    localparam int SUM_W    = ACC_WIDTH + 1;
    localparam int IDX_W    = (NO_NPL > 1) ? $clog2(NO_NPL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_NPL - 1);

    // Saturation bounds of the signed output, expressed at sum width.
    localparam logic signed [SUM_W-1:0] OUT_MAX =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        STREAM  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             done_nxt;
    logic             capture;
    logic             is_last;

    // Job operands frozen at start, and the per-neuron result buffer.
    logic signed [ACC_WIDTH-1:0]  acc_p0  [NO_NPL];
    logic signed [BIAS_WIDTH-1:0] bias_p0 [NO_NPL];
    logic                         lin_p0;
    logic signed [OUT_WIDTH-1:0]  res_p1  [NO_NPL];

    // Bias is scaled up to the accumulator's fixed-point position before adding.
    function automatic logic signed [SUM_W-1:0] bias_sum(
        input logic signed [ACC_WIDTH-1:0]  acc,
        input logic signed [BIAS_WIDTH-1:0] bias
    );
        logic signed [SUM_W-1:0] acc_x;
        logic signed [SUM_W-1:0] bias_x;
        acc_x  = {acc[ACC_WIDTH-1], acc};
        bias_x = {{(SUM_W-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
        return acc_x + (bias_x <<< SHIFT);
    endfunction

    // Clamp a rescaled value into the signed OUT_WIDTH range.
    function automatic logic signed [OUT_WIDTH-1:0] sat_out(
        input logic signed [SUM_W-1:0] v
    );
        if (v > OUT_MAX) begin
            return OUT_MAX[OUT_WIDTH-1:0];
        end else if (v < OUT_MIN) begin
            return OUT_MIN[OUT_WIDTH-1:0];
        end
        return v[OUT_WIDTH-1:0];
    endfunction

    // ReLU zeroes negative sums; for non-negative sums the arithmetic and the
    // logical shift agree, so both modes share one floor-toward-minus-infinity shift.
    function automatic logic signed [OUT_WIDTH-1:0] activate(
        input logic signed [ACC_WIDTH-1:0]  acc,
        input logic signed [BIAS_WIDTH-1:0] bias,
        input logic                         lin
    );
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] scaled;
        sum = bias_sum(acc, bias);
        if (!lin && sum[SUM_W-1]) begin
            return '0;
        end
        scaled = sum >>> SHIFT;
        return sat_out(scaled);
    endfunction

    assign is_last = (idx == LAST_IDX);

    // Control state register; reset aborts any job in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic: start only from IDLE, one neuron per COMPUTE cycle,
    // one beat per accepted STREAM transfer.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (act_fn_en) begin
                    capture   = 1'b1;
                    state_nxt = COMPUTE;
                    idx_nxt   = '0;
                end
            end
            COMPUTE: begin
                if (is_last) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            STREAM: begin
                if (stream.out_ready) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Capture stage: freeze the job operands so the MAC may move on immediately.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NO_NPL; k++) begin
                acc_p0[k]  <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
                bias_p0[k] <= bias_in[k*BIAS_WIDTH +: BIAS_WIDTH];
            end
            lin_p0 <= feed_through;
        end
    end

    // Compute stage: activate one neuron per cycle into the result buffer.
    always_ff @(posedge clk) begin
        if (state == COMPUTE) begin
            res_p1[idx] <= activate(acc_p0[idx], bias_p0[idx], lin_p0);
        end
    end

    // Stream outputs read straight from the buffer, so they hold while stalled
    // and are forced to zero outside STREAM.
    always_comb begin
        stream.out_valid = (state == STREAM);
        stream.out_data  = '0;
        stream.out_last  = 1'b0;
        if (state == STREAM) begin
            stream.out_data = res_p1[idx];
            stream.out_last = is_last;
        end
    end

    assign busy = (state != IDLE);

endmodule
